// File: rtl/nbcac_encoder_29_if.sv
// Handshake bundle between a data source/sink and the 29-wire NBCAC encoder.
interface nbcac_encoder_29_if;
  logic [19:0] datain;
  logic        in_valid;
  logic        in_ready;
  logic [29:1] codeout;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  modport master (
    output datain, in_valid, out_ready,
    input  in_ready, codeout, out_valid, busy
  );

  modport slave (
    input  datain, in_valid, out_ready,
    output in_ready, codeout, out_valid, busy
  );
endinterface

// File: rtl/nbcac_encoder_29.sv
// Iterative Fibonacci-numeral crosstalk-avoidance encoder, 20-bit data -> 29 wires, MSB wire first.
// Define NBCAC_ENC_DUALSTEP_EN to resolve two wires per cycle (15-cycle latency instead of 29).
module nbcac_encoder_29 (
  input logic clock,
  input logic rst_n,
  nbcac_encoder_29_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [19:0] r;
  logic [4:0]  k;
  logic        dprev;
  logic [29:1] work, work_nxt, codeout_q;
  logic        out_valid_q, busy_q;
  logic [19:0] r_nxt;
  logic [4:0]  k_nxt;
  logic        d_nxt;
  logic [20:0] s1;
`ifdef NBCAC_ENC_DUALSTEP_EN
  logic [20:0] s2;
`endif
  logic        load;

  function automatic logic [19:0] w_rom(input logic [4:0] idx);
    case (idx)
      5'd1:  return 20'd1;
      5'd2:  return 20'd1;
      5'd3:  return 20'd2;
      5'd4:  return 20'd3;
      5'd5:  return 20'd5;
      5'd6:  return 20'd8;
      5'd7:  return 20'd13;
      5'd8:  return 20'd21;
      5'd9:  return 20'd34;
      5'd10: return 20'd55;
      5'd11: return 20'd89;
      5'd12: return 20'd144;
      5'd13: return 20'd233;
      5'd14: return 20'd377;
      5'd15: return 20'd610;
      5'd16: return 20'd987;
      5'd17: return 20'd1597;
      5'd18: return 20'd2584;
      5'd19: return 20'd4181;
      5'd20: return 20'd6765;
      5'd21: return 20'd10946;
      5'd22: return 20'd17711;
      5'd23: return 20'd28657;
      5'd24: return 20'd46368;
      5'd25: return 20'd75025;
      5'd26: return 20'd121393;
      5'd27: return 20'd196418;
      5'd28: return 20'd317811;
      5'd29: return 20'd514229;
      5'd30: return 20'd832040;
      default: return 20'd0;
    endcase
  endfunction

  // One wire decision: returns {d_k, remainder after subtracting d_k*w_k}.
  // The middle band copies the previous wire, which is what keeps 010/101 off the bus.
  function automatic logic [20:0] step(input logic [19:0] rem, input logic [4:0] idx,
                                       input logic dp);
    logic [19:0] wk, wk1;
    logic        d;
    wk  = w_rom(idx);
    wk1 = w_rom(idx + 5'd1);
    if (rem >= wk1)    d = 1'b1;
    else if (rem < wk) d = 1'b0;
    else               d = dp;
    return {d, d ? rem - wk : rem};
  endfunction

  always_comb begin
    s1             = step(r, k, dprev);
    work_nxt       = work;
    work_nxt[k]    = s1[20];
    r_nxt          = s1[19:0];
    d_nxt          = s1[20];
    k_nxt          = k - 5'd1;
`ifdef NBCAC_ENC_DUALSTEP_EN
    s2 = step(s1[19:0], k - 5'd1, s1[20]);
    if (k >= 5'd2) begin
      work_nxt[k - 5'd1] = s2[20];
      r_nxt              = s2[19:0];
      d_nxt              = s2[20];
      k_nxt              = k - 5'd2;
    end
`endif
  end

  assign bus.in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
  assign bus.codeout   = codeout_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign load          = bus.in_valid && bus.in_ready;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      r           <= '0;
      k           <= '0;
      dprev       <= 1'b0;
      work        <= '0;
      codeout_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (load) begin
      // Covers both a fresh word from IDLE and a back-to-back word out of DONE.
      state       <= RUN;
      r           <= bus.datain;
      k           <= 5'd29;
      dprev       <= 1'b0;
      work        <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      case (state)
        RUN: begin
          r     <= r_nxt;
          k     <= k_nxt;
          dprev <= d_nxt;
          work  <= work_nxt;
          if (k == 5'd1) begin
            codeout_q   <= work_nxt;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_nbcac_encoder_29.sv
// Directed bench for nbcac_encoder_29: hand-computed codewords plus weight-sum and pattern properties.
module tb_nbcac_encoder_29;
`ifdef NBCAC_ENC_DUALSTEP_EN
  localparam int LAT = 15;
`else
  localparam int LAT = 29;
`endif

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc_cnt = 0;
  int   n, t1, t2;

  nbcac_encoder_29_if bus();
  nbcac_encoder_29 dut (.clock(clock), .rst_n(rst_n), .bus(bus));

  always #5 clock = ~clock;
  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [31:0] code_sum(input logic [29:1] c);
    logic [31:0] s;
    int a, b, t;
    s = 0; a = 1; b = 1;
    for (int i = 1; i <= 29; i++) begin
      if (c[i]) s += 32'(a);
      t = a + b; a = b; b = t;
    end
    return s;
  endfunction

  function automatic logic pat_ok(input logic [29:1] c);
    logic ok;
    ok = 1'b1;
    for (int i = 1; i <= 27; i++)
      if ((c[i+1] != c[i]) && (c[i+2] != c[i+1])) ok = 1'b0;
    return ok;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid();
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
  endtask

  task automatic run_word(input logic [19:0] v, input logic [28:0] exp_code,
                          input bit chk_code, input int hold);
    logic [28:0] c;
    @(negedge clock);
    bus.datain = v; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clock); #1;
    bus.in_valid = 1'b0; bus.datain = 20'hABCDE;
    chk("busy_after_hs", 32'(bus.busy), 32'd1);
    chk("in_ready_run", 32'(bus.in_ready), 32'd0);
    wait_valid();
    chk("latency", n, LAT);
    c = bus.codeout;
    if (chk_code) chk("code", 32'(c), 32'(exp_code));
    chk("weight_sum", code_sum(c), 32'(v));
    chk("no_010_101", 32'(pat_ok(c)), 32'd1);
    chk("final_rem", 32'(dut.r), 32'd0);
    chk("busy_done", 32'(bus.busy), 32'd0);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      @(posedge clock); #1;
      chk("hold_code", 32'(bus.codeout), 32'(c));
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clock); #1;
    bus.out_ready = 1'b0;
    chk("consumed", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    bus.datain = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock); rst_n = 1'b1;
    @(negedge clock);
    chk("rst_codeout", 32'(bus.codeout), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);

    // Hand-derived codewords (bit k of the code is wire k).
    run_word(20'd0,      29'h0000000, 1'b1, 0);
    run_word(20'd1,      29'h0000001, 1'b1, 1);
    run_word(20'd2,      29'h0000003, 1'b1, 2);
    run_word(20'd3,      29'h0000006, 1'b1, 0);
    run_word(20'd4,      29'h0000007, 1'b1, 3);
    run_word(20'd5,      29'h000000C, 1'b1, 1);
    run_word(20'd514229, 29'h0C000000, 1'b1, 2);
    run_word(20'hFFFFF,  29'h0, 1'b0, 1);

    for (int i = 0; i < 40; i++)
      run_word(20'($urandom), 29'h0, 1'b0, int'($urandom_range(0, 3)));

    // Back-to-back: in_valid and out_ready held high across the commit.
    @(negedge clock);
    bus.datain = 20'd3; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clock); #1;
    bus.datain = 20'd5;
    wait_valid();
    t1 = cyc_cnt;
    chk("b2b_code_a", 32'(bus.codeout), 32'h6);
    @(posedge clock); #1;
    chk("b2b_a_taken", 32'(bus.out_valid), 32'd0);
    chk("b2b_busy", 32'(bus.busy), 32'd1);
    wait_valid();
    t2 = cyc_cnt;
    chk("b2b_code_b", 32'(bus.codeout), 32'hC);
    chk("b2b_spacing", t2 - t1, LAT + 1);
    bus.in_valid = 1'b0;
    @(posedge clock); #1;
    bus.out_ready = 1'b0;
    chk("b2b_b_taken", 32'(bus.out_valid), 32'd0);
    chk("b2b_idle", 32'(bus.in_ready), 32'd1);

    // Reset in the middle of a word: nothing is committed and codeout clears.
    @(negedge clock);
    bus.datain = 20'd514229; bus.in_valid = 1'b1;
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clock);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_codeout", 32'(bus.codeout), 32'd0);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    @(negedge clock); rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (40) @(posedge clock);
    #1;
    chk("midrst_no_commit", 32'(bus.out_valid), 32'd0);
    chk("midrst_code_zero", 32'(bus.codeout), 32'd0);
    chk("idle_after_rst", 32'(bus.in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
